sort_stream_param: RTL and testbench

- Parametrised streaming sorter for IEEE-754 single-precision values, the next generation of the fixed 8-entry sorter.
- Accepts a frame of up to DEPTH values, one per cycle, over a valid/ready handshake.
- Inserts each value into a sorted register array as it arrives, then drains the frame in ascending or descending order with backpressure.
- Sits between a sample producer and downstream median/percentile logic.

---
 rtl/sort_stream_param.sv | 182 ++++++++++++++++++
 tb/tb_sort_stream_param.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_param.sv
// Streaming insertion sorter for IEEE-754 style values.
// Frames of up to DEPTH beats are inserted into a sorted register array as
// they arrive, then drained in ascending or descending order with backpressure.
module sort_stream_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             descend,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [WIDTH-1:0] entry     [DEPTH];
  logic [WIDTH-1:0] entry_src [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] rd_idx;
  logic             desc_q;

  logic             desc_eff;
  logic             accept;
  logic             fill_done;
  logic             out_fire;
  logic             drain_done;
  logic [WIDTH-1:0] key_in;
  logic [DEPTH-1:0] prec;
  logic [DEPTH-1:0] shift;
  logic [DEPTH-1:0] prev_shift;
  logic [DEPTH-1:0] prev_vld;
  logic [DEPTH-1:0] load_prev;
  logic [DEPTH-1:0] load_new;

  // Map a sign-magnitude float onto an unsigned key with the same ordering.
  function automatic logic [WIDTH-1:0] key_of(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? ~x : (x | SIGN_BIT);
  endfunction

  // Handshake qualifiers derived from state only, keeping them loop-free.
  always_comb begin
    accept     = in_valid && (state == FILL);
    fill_done  = in_last || (count == LAST_CNT);
    out_fire   = out_ready && (state == DRAIN);
    drain_done = out_fire && (rd_idx == out_count - 1'b1);
    // descend is taken live on the first beat, then from the latched copy.
    desc_eff   = (count == '0) ? descend : desc_q;
  end

  // Parallel compare of the incoming beat against every stored entry.
  // The array is kept sorted, so prec is a thermometer code: entries from the
  // insertion point upward all shift one slot, equal keys never shift.
  always_comb begin
    key_in = key_of(in_data);
    prec   = '0;
    shift  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      prec[i]  = desc_eff ? (key_in > key_of(entry[i])) : (key_in < key_of(entry[i]));
      shift[i] = vld[i] && prec[i];
    end
    prev_shift = {shift[DEPTH-2:0], 1'b0};
    prev_vld   = {vld[DEPTH-2:0], 1'b1};
    load_prev  = prev_shift;
    load_new   = ~prev_shift & (shift | (~vld & prev_vld));
  end

  // Source for a shift-up move: slot i takes slot i-1; slot 0 never shifts.
  always_comb begin
    entry_src[0] = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      entry_src[i] = entry[i-1];
    end
  end

  // Entry data storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (load_prev[i]) begin
          entry[i] <= entry_src[i];
        end else if (load_new[i]) begin
          entry[i] <= in_data;
        end
      end
    end
  end

  // Entry valid flags fill contiguously from slot 0 and clear after a drain.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (drain_done) begin
      vld <= '0;
    end else if (accept) begin
      vld <= {vld[DEPTH-2:0], 1'b1};
    end
  end

  // Element counter, frame length latch, sort-order latch and read pointer.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count     <= '0;
      rd_idx    <= '0;
      out_count <= '0;
      desc_q    <= 1'b0;
    end else begin
      if (accept) begin
        count <= count + 1'b1;
        if (count == '0) begin
          desc_q <= descend;
        end
        if (fill_done) begin
          out_count <= count + 1'b1;
        end
      end
      if (drain_done) begin
        count  <= '0;
        rd_idx <= '0;
      end else if (out_fire) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; out_data is muxed from the array by rd_idx.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (accept && fill_done) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_idx == out_count - 1'b1);
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (rd_idx == CNT_W'(i)) begin
            out_data = entry[i];
          end
        end
        if (drain_done) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

endmodule

// File: tb/tb_sort_stream_param.sv
// Self-checking bench for sort_stream_param: a rank-based reference model is
// compared against the DUT every cycle, plus literal expected sequences.
module tb_sort_stream_param;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          descend = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic [CW-1:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  sort_stream_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .descend   (descend),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_count (out_count)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [31:0] cur[$];
  logic [31:0] exp_q[$];
  bit          desc_m   = 1'b0;
  bit          draining = 1'b0;
  int          frame_n  = 0;

  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_cnt[$];

  // Real-number order of sign-magnitude values, -0 strictly before +0.
  function automatic bit less_f(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic bit prec_f(input logic [31:0] a, input logic [31:0] b, input bit desc);
    return desc ? less_f(b, a) : less_f(a, b);
  endfunction

  // Output position = elements strictly ahead + earlier-arrived ties.
  task automatic build_expected();
    logic [31:0] res [D];
    int n;
    n = cur.size();
    for (int i = 0; i < n; i++) begin
      int r;
      r = 0;
      for (int j = 0; j < n; j++) begin
        if (prec_f(cur[j], cur[i], desc_m)) r++;
        else if (j < i && !prec_f(cur[i], cur[j], desc_m)) r++;
      end
      res[r] = cur[i];
    end
    for (int i = 0; i < n; i++) exp_q.push_back(res[i]);
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge rst);
      if (rst) begin
        cur.delete();
        exp_q.delete();
        draining = 1'b0;
        frame_n  = 0;
      end else if (!draining) begin
        if (in_valid) begin
          if (cur.size() == 0) desc_m = descend;
          cur.push_back(in_data);
          if (in_last || cur.size() == D) begin
            build_expected();
            frame_n = cur.size();
            cur.delete();
            draining = 1'b1;
          end
        end
      end else if (out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) draining = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!rst) begin
        chk("in_ready", 32'(in_ready), 32'(!draining));
        chk("out_valid", 32'(out_valid), 32'(draining));
        if (draining && exp_q.size() > 0) begin
          chk("out_data", out_data, exp_q[0]);
          chk("out_last", 32'(out_last), 32'(exp_q.size() == 1));
          chk("out_count", 32'(out_count), 32'(frame_n));
        end
        if (out_valid && out_ready) begin
          got_data.push_back(out_data);
          got_last.push_back(out_last);
          got_cnt.push_back(32'(out_count));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", n);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (draining && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: still draining after %0d cycles, expected idle", n);
    end
    step();
  endtask

  task automatic wait_got(input int k);
    int n;
    n = 0;
    while (got_data.size() < k && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL output_timeout: got %0d outputs, expected %0d", got_data.size(), k);
    end
  endtask

  task automatic check_seq(input string tag, input int base, input logic [31:0] e [8], input int n);
    if (got_data.size() < base + n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_len: got %0d outputs, expected %0d", tag, got_data.size() - base, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        chk({tag, "_data"}, got_data[base+i], e[i]);
        chk({tag, "_last"}, 32'(got_last[base+i]), 32'(i == n - 1));
        chk({tag, "_count"}, got_cnt[base+i], n);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] stim [8];
    logic [31:0] e    [8];
    int base;

    #12;
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // 1: full frame ascending
    stim = '{32'h40800000, 32'h40A00000, 32'h40400000, 32'hC1200000,
             32'h40280000, 32'h40E00000, 32'hC0800000, 32'h40000000};
    base = got_data.size();
    descend = 1'b0;
    for (int i = 0; i < 8; i++) send(stim[i], i == 7);
    chk("t1_latency_valid", 32'(out_valid), 32'd1);
    wait_idle();
    e = '{32'hC1200000, 32'hC0800000, 32'h40000000, 32'h40280000,
          32'h40400000, 32'h40800000, 32'h40A00000, 32'h40E00000};
    check_seq("t1", base, e, 8);

    // 2: same stream descending; descend flips mid-frame and must be ignored
    base = got_data.size();
    descend = 1'b1;
    send(stim[0], 1'b0);
    descend = 1'b0;
    for (int i = 1; i < 8; i++) send(stim[i], i == 7);
    wait_idle();
    e = '{32'h40E00000, 32'h40A00000, 32'h40800000, 32'h40400000,
          32'h40280000, 32'h40000000, 32'hC0800000, 32'hC1200000};
    check_seq("t2", base, e, 8);

    // 3: short frame with signed zeros
    base = got_data.size();
    send(32'h40400000, 1'b0);
    send(32'h00000000, 1'b0);
    send(32'h80000000, 1'b1);
    chk("t3_in_ready_drain", 32'(in_ready), 32'd0);
    wait_idle();
    e = '{32'h80000000, 32'h00000000, 32'h40400000, 0, 0, 0, 0, 0};
    check_seq("t3", base, e, 3);

    // 4: backpressure for 4 cycles starting at output index 2, duplicates
    base = got_data.size();
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h3F800000, 1'b0);
    send(32'hBF800000, 1'b1);
    wait_got(base + 2);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_data", out_data, 32'h3F800000);
      chk("t4_hold_last", 32'(out_last), 32'd0);
    end
    out_ready = 1'b1;
    wait_idle();
    e = '{32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
          32'h40000000, 0, 0, 0};
    check_seq("t4", base, e, 5);

    // 5a: reset after 5 beats of a frame
    for (int i = 0; i < 5; i++) send(stim[i], 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_fill_rst");
    step();
    rst = 1'b0;
    step();

    // 5b: reset in the middle of a drain
    base = got_data.size();
    for (int i = 0; i < 4; i++) send(stim[i], i == 3);
    wait_got(base + 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_drain_rst");
    step();
    rst = 1'b0;
    step();

    // 5c: fresh 2-element frame after reset
    base = got_data.size();
    send(32'h41000000, 1'b0);
    send(32'hC0000000, 1'b1);
    wait_idle();
    e = '{32'hC0000000, 32'h41000000, 0, 0, 0, 0, 0, 0};
    check_seq("t5", base, e, 2);

    // 6: back-to-back, second frame presented while the first drains
    base = got_data.size();
    descend = 1'b0;
    send(32'h40400000, 1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'hBF800000, 1'b1);
    descend = 1'b1;
    send(32'h00000000, 1'b0);
    send(32'h80000000, 1'b0);
    send(32'h41200000, 1'b1);
    descend = 1'b0;
    wait_idle();
    e = '{32'hBF800000, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, 0};
    check_seq("t6a", base, e, 4);
    e = '{32'h41200000, 32'h00000000, 32'h80000000, 0, 0, 0, 0, 0};
    check_seq("t6b", base + 4, e, 3);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
